// File: rtl/rx_cmd_parser.sv
// Frames the RX PIE bit stream into Gen2 commands (opcode decode, length count, CRC-5/CRC-16 check).
// Latency: cmd_done 1 clk after the final bit strobe; no backpressure, strobes are ignored until aborted.
module rx_cmd_parser (
   input  logic        clk,
   input  logic        reset,
   input  logic        bitin,
   input  logic        bitclk,
   input  logic        rx_overflow_reset,
   output logic        cmd_done,
   output logic [2:0]  cmd_code,
   output logic        cmd_err,
   output logic [1:0]  session,
   output logic [3:0]  q,
   output logic        dr,
   output logic        trext,
   output logic        target,
   output logic [1:0]  m,
   output logic [1:0]  sel,
   output logic [2:0]  updn,
   output logic [15:0] rn16
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

   localparam logic [4:0]  CRC5_PRESET  = 5'b01001;
   localparam logic [15:0] CRC16_PRESET = 16'hFFFF;
   localparam logic [15:0] CRC16_RESID  = 16'h1D0F;
   localparam logic [7:0]  OP_REQ_RN    = 8'b1100_0001;

   localparam logic [2:0] C_QREP = 3'd1;
   localparam logic [2:0] C_ACK  = 3'd2;
   localparam logic [2:0] C_QRY  = 3'd3;
   localparam logic [2:0] C_QADJ = 3'd4;
   localparam logic [2:0] C_REQ  = 3'd5;
   localparam logic [2:0] C_UNSP = 3'd7;

   state_t      state_q;
   logic        bitclk_q;
   logic [5:0]  cnt_q, cnt_d;
   logic [39:0] sr_q, sr_d;
   logic [7:0]  op_q, op_d;
   logic [4:0]  crc5_q, crc5_d;
   logic [15:0] crc16_q, crc16_d;
   logic        strobe;
   logic [2:0]  fin_code;

   always_comb begin
      strobe  = bitclk & ~bitclk_q;
      cnt_d   = (cnt_q == 6'd40) ? cnt_q : cnt_q + 6'd1;
      sr_d    = (cnt_q == 6'd40) ? sr_q : {sr_q[38:0], bitin};
      op_d    = op_q;
      if (cnt_q < 6'd8) begin
         op_d[3'd7 - cnt_q[2:0]] = bitin;
      end
      crc5_d  = {crc5_q[3:0], 1'b0} ^ ({5{crc5_q[4] ^ bitin}} & 5'b01001);
      crc16_d = {crc16_q[14:0], 1'b0} ^ ({16{crc16_q[15] ^ bitin}} & 16'h1021);

      // Opcode bits are only trusted up to the current count, so each
      // decision point looks at just the prefix received so far.
      fin_code = 3'd0;
      case (cnt_d)
         6'd4: begin
            if (op_d[7:6] == 2'b00)
               fin_code = C_QREP;
            else if (op_d[7:5] == 3'b101)
               fin_code = C_UNSP;
         end
         6'd8:  if (op_d[7:6] == 2'b11 && op_d != OP_REQ_RN) fin_code = C_UNSP;
         6'd9:  if (op_d[7:4] == 4'b1001) fin_code = C_QADJ;
         6'd18: if (op_d[7:6] == 2'b01) fin_code = C_ACK;
         6'd22: if (op_d[7:4] == 4'b1000) fin_code = C_QRY;
         6'd40: if (op_d == OP_REQ_RN) fin_code = C_REQ;
         default: fin_code = 3'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bitclk_q <= 1'b0;
         cnt_q    <= 6'd0;
         sr_q     <= 40'd0;
         op_q     <= 8'd0;
         crc5_q   <= CRC5_PRESET;
         crc16_q  <= CRC16_PRESET;
         cmd_done <= 1'b0;
         cmd_code <= 3'd0;
         cmd_err  <= 1'b0;
         session  <= 2'd0;
         q        <= 4'd0;
         dr       <= 1'b0;
         trext    <= 1'b0;
         target   <= 1'b0;
         m        <= 2'd0;
         sel      <= 2'd0;
         updn     <= 3'd0;
         rn16     <= 16'd0;
      end else begin
         bitclk_q <= bitclk;
         cmd_done <= 1'b0;
         if (rx_overflow_reset) begin
            // Abort beats a coincident strobe; decoded outputs stay as they were.
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            sr_q    <= 40'd0;
            op_q    <= 8'd0;
            crc5_q  <= CRC5_PRESET;
            crc16_q <= CRC16_PRESET;
         end else if (strobe && state_q != S_DONE) begin
            state_q <= S_RECV;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            op_q    <= op_d;
            crc5_q  <= crc5_d;
            crc16_q <= crc16_d;
            if (fin_code != 3'd0) begin
               state_q  <= S_DONE;
               cmd_done <= 1'b1;
               cmd_code <= fin_code;
               case (fin_code)
                  C_QREP: begin
                     session <= sr_d[1:0];
                     cmd_err <= 1'b0;
                  end
                  C_ACK: begin
                     rn16    <= sr_d[15:0];
                     cmd_err <= 1'b0;
                  end
                  C_QRY: begin
                     dr      <= sr_d[17];
                     m       <= sr_d[16:15];
                     trext   <= sr_d[14];
                     sel     <= sr_d[13:12];
                     session <= sr_d[11:10];
                     target  <= sr_d[9];
                     q       <= sr_d[8:5];
                     cmd_err <= (crc5_d != 5'd0);
                  end
                  C_QADJ: begin
                     session <= sr_d[4:3];
                     updn    <= sr_d[2:0];
                     cmd_err <= 1'b0;
                  end
                  C_REQ: begin
                     rn16    <= sr_d[31:16];
                     cmd_err <= (crc16_d != CRC16_RESID);
                  end
                  default: cmd_err <= 1'b1;
               endcase
            end
         end
      end
   end

endmodule
